// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W        = 6;
    localparam int unsigned DMEM_DATA_W        = 32;
    localparam int unsigned DMEM_NUM_BLOCKS    = 64;
    localparam int unsigned DMEM_ACCESS_CYCLES = 5;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_latency_counter.sv
// Access-latency counter: load to 1, count up until it reaches ACCESS_CYCLES, flag done there.
module dmem_latency_counter
    import dmem_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = DMEM_ACCESS_CYCLES,
    parameter int unsigned CNT_W         = $clog2(ACCESS_CYCLES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (incr && !done) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(ACCESS_CYCLES));

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency block memory behind the data cache; stalls the cache via mem_busywait.
// Define DMEM_CLEAR_ON_RESET_EN to zero the whole array on every reset edge.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = DMEM_ACCESS_CYCLES,
    parameter int unsigned NUM_BLOCKS    = DMEM_NUM_BLOCKS,
    parameter int unsigned ADDR_W        = DMEM_ADDR_W,
    parameter int unsigned DATA_W        = DMEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_writedata,
    output logic [DATA_W-1:0] mem_readdata,
    output logic              mem_busywait
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);

    dmem_state_e       state_q, state_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  count;
    logic              done;
    logic              cnt_load;
    logic              cnt_incr;
    logic              req;
    logic [DATA_W-1:0] mem [NUM_BLOCKS];

    assign req = mem_read | mem_write;

    dmem_latency_counter #(
        .ACCESS_CYCLES (ACCESS_CYCLES),
        .CNT_W         (CNT_W)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .incr  (cnt_incr),
        .count (count),
        .done  (done)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_incr     = 1'b0;
        mem_busywait = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_busywait = req;
                if (req) begin
                    state_d  = ACCESS;
                    cnt_load = 1'b1;
                end
            end
            ACCESS: begin
                mem_busywait = !done;
                cnt_incr     = 1'b1;
                if (done) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (!reset) begin
            mem_busywait = 1'b0;
        end
    end

    // Read data loads on the edge that makes count reach ACCESS_CYCLES; with a
    // single-cycle access that is the IDLE->ACCESS edge itself.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_readdata <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                write_q <= mem_write;
                addr_q  <= mem_address;
                wdata_q <= mem_writedata;
                if (ACCESS_CYCLES == 1 && !mem_write) begin
                    mem_readdata <= mem[mem_address];
                end
            end
            if (state_q == ACCESS && !write_q && ACCESS_CYCLES > 1 &&
                count == CNT_W'(ACCESS_CYCLES - 1)) begin
                mem_readdata <= mem[addr_q];
            end
        end
    end

    always_ff @(posedge clock) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (!reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                mem[i] <= '0;
            end
        end else
`endif
        if (reset && state_q == ACCESS && done && write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (5-cycle instance plus a 1-cycle instance).
module tb_data_memory_responder;

    localparam int unsigned AC = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_busywait;

    logic        rd1, wr1;
    logic [5:0]  addr1;
    logic [31:0] wdata1, rdata1;
    logic        busy1;

    always #5 clock = ~clock;

    data_memory_responder #(
        .ACCESS_CYCLES (AC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    data_memory_responder #(
        .ACCESS_CYCLES (1)
    ) dut1 (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (rd1),
        .mem_write     (wr1),
        .mem_address   (addr1),
        .mem_writedata (wdata1),
        .mem_readdata  (rdata1),
        .mem_busywait  (busy1)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] model  [64];
    logic [31:0] model1 [64];
    logic [31:0] exp_q  [$];
    logic [31:0] last_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] d);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = a;
        mem_writedata = d;
        if (wr) model[a] = d;
        else if (rd) exp_q.push_back(model[a]);
    endtask

    // Called in cycle 0 of an access; returns inside the completion cycle.
    task automatic complete(input string tag, input bit rd_op, input bit disturb);
        #1 check_eq({tag, " busy c0"}, 32'(mem_busywait), 32'd1);
        for (int n = 1; n <= int'(AC); n++) begin
            @(posedge clock); #1;
            if (n == 1 && disturb) begin
                mem_address   = ~mem_address;
                mem_writedata = ~mem_writedata;
            end
            check_eq($sformatf("%s busy c%0d", tag, n), 32'(mem_busywait), 32'(n < int'(AC)));
        end
        if (rd_op) begin
            if (exp_q.size() == 0) begin
                check_eq({tag, " scoreboard empty"}, 32'd0, 32'd1);
            end else begin
                last_rd = exp_q.pop_front();
            end
        end
        check_eq({tag, " rdata"}, mem_readdata, last_rd);
    endtask

    task automatic idle_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic reset_models();
        last_rd = '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 64; i++) begin
            model[i]  = '0;
            model1[i] = '0;
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        mem_read = 1'b1; mem_write = 1'b0; mem_address = '0; mem_writedata = '0;
        rd1 = 1'b1; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        reset_models();
        @(posedge clock); @(posedge clock); #1;
        check_eq("reset busy", 32'(mem_busywait), 32'd0);
        check_eq("reset rdata", mem_readdata, 32'd0);
        check_eq("reset busy1", 32'(busy1), 32'd0);
        check_eq("reset rdata1", rdata1, 32'd0);
        reset = 1'b1; mem_read = 1'b0; rd1 = 1'b0;
        @(posedge clock); #1;
        check_eq("idle busy", 32'(mem_busywait), 32'd0);

        issue(0, 1, 6'h05, 32'hDEADBEEF); complete("wr05", 0, 0); idle_cycle();
        issue(1, 0, 6'h05, '0);           complete("rd05", 1, 0); idle_cycle();
        issue(0, 1, 6'h01, 32'hCAFEF00D); complete("wr01", 0, 0); idle_cycle();

        // Writeback immediately followed by refill, no gap.
        issue(0, 1, 6'h21, 32'h11223344); complete("wr21", 0, 0);
        issue(1, 0, 6'h01, '0); @(posedge clock); complete("b2b rd01", 1, 0);
        issue(1, 0, 6'h21, '0); @(posedge clock); complete("b2b rd21", 1, 0);
        idle_cycle();

        // Address/data wiggled during ACCESS must not be used.
        issue(0, 1, 6'h2D, 32'h2D2D2D2D); complete("wr2D", 0, 0); idle_cycle();
        issue(0, 1, 6'h12, 32'h12345678); complete("wr12 disturbed", 0, 1); idle_cycle();
        issue(1, 0, 6'h12, '0); complete("rd12", 1, 0);
        issue(1, 0, 6'h2D, '0); @(posedge clock); complete("rd2D", 1, 0);
        idle_cycle();

        // Read and write together behave as a write with no read load.
        issue(1, 1, 6'h05, 32'h55AA55AA); complete("rdwr05", 0, 0); idle_cycle();
        issue(1, 0, 6'h05, '0); complete("rd05 after rdwr", 1, 0); idle_cycle();

        // Reset in cycle 3 of a write aborts it.
        issue(0, 1, 6'h0A, 32'h0A0A0A0A); complete("wr0A", 0, 0); idle_cycle();
        mem_write = 1'b1; mem_address = 6'h0A; mem_writedata = 32'hBADBAD00;
        #1 check_eq("abort busy c0", 32'(mem_busywait), 32'd1);
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b0;
        #1 check_eq("abort busy reset low", 32'(mem_busywait), 32'd0);
        @(posedge clock); #1;
        check_eq("abort rdata", mem_readdata, 32'd0);
        check_eq("abort busy after edge", 32'(mem_busywait), 32'd0);
        mem_write = 1'b0; reset = 1'b1;
        reset_models();
        @(posedge clock); #1;
        issue(1, 0, 6'h0A, '0); complete("rd0A after abort", 1, 0); idle_cycle();

        // Single-cycle instance: write 3F, reset, read 3F back.
        wr1 = 1'b1; addr1 = 6'h3F; wdata1 = 32'h3F3F3F3F; model1[6'h3F] = 32'h3F3F3F3F;
        #1 check_eq("ac1 wr busy c0", 32'(busy1), 32'd1);
        @(posedge clock); #1;
        check_eq("ac1 wr busy c1", 32'(busy1), 32'd0);
        wr1 = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        reset_models();
        rd1 = 1'b1; addr1 = 6'h3F;
        #1 check_eq("ac1 rd busy c0", 32'(busy1), 32'd1);
        @(posedge clock); #1;
        check_eq("ac1 rd busy c1", 32'(busy1), 32'd0);
        check_eq("ac1 rd rdata", rdata1, model1[6'h3F]);
        rd1 = 1'b0;
        @(posedge clock); #1;

        // Main instance contents across that reset.
        issue(1, 0, 6'h05, '0); complete("rd05 after reset", 1, 0); idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
